trap_ctrl: RTL and testbench

- Sequences machine-mode trap entry and `mret` return after an instruction retires from writeback.
- Captures the trap reported by writeback and flushes the pipeline.
- Writes `mepc`, `mcause`, `mtval` and `mstatus` one at a time through the single CSR write port, then redirects fetch to the handler (or, for `mret`, back to `mepc`).
- Sits between the writeback stage, the CSR file and the fetch stage.

---
 rtl/trap_ctrl.sv | 151 +++++++++++++++
 tb/tb_trap_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / mret return sequencer: captures the retiring trap,
// flushes the pipeline, writes the trap CSRs one by one, then redirects fetch.
module trap_ctrl #(
  parameter logic [11:0] MSTATUS_ADDR = 12'h300,
  parameter logic [11:0] MEPC_ADDR    = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
  parameter logic [11:0] MTVAL_ADDR   = 12'h343,
  parameter bit          VECTORED_EN  = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        trap_valid_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_tval_i,
  input  logic        mret_valid_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mstatus_i,
  input  logic        csr_wready_i,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE, WR_MEPC, WR_MCAUSE, WR_MTVAL, WR_MSTATUS, MRET_MSTATUS, REDIRECT
  } state_t;

  state_t      state;
  logic [31:0] cap_pc;
  logic [31:0] cap_cause;
  logic [31:0] cap_tval;
  logic [31:0] cap_mstatus;
  logic        cap_mret;
  logic        wr_done;

  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r        = s;
    r[7]     = s[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r        = s;
    r[3]     = s[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] trap_target(input logic [31:0] tvec, input logic [31:0] cause);
    logic [31:0] base;
    base = {tvec[31:2], 2'b00};
    if (VECTORED_EN && tvec[1:0] == 2'b01 && cause[31])
      return base + {cause[29:0], 2'b00};
    return base;
  endfunction

  assign wr_done = csr_we_o && csr_wready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cap_pc      <= '0;
      cap_cause   <= '0;
      cap_tval    <= '0;
      cap_mstatus <= '0;
      cap_mret    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trap_valid_i) begin
            cap_pc      <= trap_pc_i;
            cap_cause   <= trap_cause_i;
            cap_tval    <= trap_tval_i;
            cap_mstatus <= mstatus_i;
            cap_mret    <= 1'b0;
            state       <= WR_MEPC;
          end else if (mret_valid_i) begin
            // cap_pc doubles as the return address for mret
            cap_pc      <= mepc_i;
            cap_mstatus <= mstatus_i;
            cap_mret    <= 1'b1;
            state       <= MRET_MSTATUS;
          end
        end
        WR_MEPC:      if (wr_done) state <= WR_MCAUSE;
        WR_MCAUSE:    if (wr_done) state <= WR_MTVAL;
        WR_MTVAL:     if (wr_done) state <= WR_MSTATUS;
        WR_MSTATUS:   if (wr_done) state <= REDIRECT;
        MRET_MSTATUS: if (wr_done) state <= REDIRECT;
        REDIRECT:     state <= IDLE;
        default:      state <= IDLE;
      endcase
    end
  end

  always_comb begin
    csr_we_o         = 1'b0;
    csr_waddr_o      = '0;
    csr_wdata_o      = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    case (state)
      WR_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = MEPC_ADDR;
        csr_wdata_o = {cap_pc[31:2], 2'b00};
      end
      WR_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = MCAUSE_ADDR;
        csr_wdata_o = cap_cause;
      end
      WR_MTVAL: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = MTVAL_ADDR;
        csr_wdata_o = cap_tval;
      end
      WR_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = MSTATUS_ADDR;
        csr_wdata_o = trap_mstatus(cap_mstatus);
      end
      MRET_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = MSTATUS_ADDR;
        csr_wdata_o = mret_mstatus(cap_mstatus);
      end
      REDIRECT: begin
        // mtvec is read live here rather than captured at trap entry
        redirect_valid_o = 1'b1;
        redirect_pc_o    = cap_mret ? {cap_pc[31:2], 2'b00} : trap_target(mtvec_i, cap_cause);
      end
      default: ;
    endcase
  end

  assign busy_o  = (state != IDLE);
  assign flush_o = busy_o || trap_valid_i || mret_valid_i;

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized scoreboard bench for trap_ctrl; two instances (vectored on/off)
// share stimulus, a monitor pops expected CSR writes and redirect targets.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_valid, mret_valid, csr_wready;
  logic [31:0] trap_pc, trap_cause, trap_tval, mtvec, mepc, mstatus;

  logic        we0, we1, fl0, fl1, rv0, rv1, bz0, bz1;
  logic [11:0] wa0, wa1;
  logic [31:0] wd0, wd1, rp0, rp1;

  int checks = 0;
  int errors = 0;

  logic [43:0] exp_wr[$];
  logic [31:0] exp_rd_vec[$];
  logic [31:0] exp_rd_dir[$];

  always #5 clk = ~clk;

  trap_ctrl #(.VECTORED_EN(1'b1)) u_vec (
    .clk_i(clk), .rst_i(rst), .trap_valid_i(trap_valid), .trap_pc_i(trap_pc),
    .trap_cause_i(trap_cause), .trap_tval_i(trap_tval), .mret_valid_i(mret_valid),
    .mtvec_i(mtvec), .mepc_i(mepc), .mstatus_i(mstatus), .csr_wready_i(csr_wready),
    .csr_we_o(we0), .csr_waddr_o(wa0), .csr_wdata_o(wd0), .flush_o(fl0),
    .redirect_valid_o(rv0), .redirect_pc_o(rp0), .busy_o(bz0));

  trap_ctrl #(.VECTORED_EN(1'b0)) u_dir (
    .clk_i(clk), .rst_i(rst), .trap_valid_i(trap_valid), .trap_pc_i(trap_pc),
    .trap_cause_i(trap_cause), .trap_tval_i(trap_tval), .mret_valid_i(mret_valid),
    .mtvec_i(mtvec), .mepc_i(mepc), .mstatus_i(mstatus), .csr_wready_i(csr_wready),
    .csr_we_o(we1), .csr_waddr_o(wa1), .csr_wdata_o(wd1), .flush_o(fl1),
    .redirect_valid_o(rv1), .redirect_pc_o(rp1), .busy_o(bz1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: mstatus update rules and redirect target as plain arithmetic
  function automatic logic [31:0] m_trap_ms(input logic [31:0] s);
    return (s & ~32'h0000_1888) | (((s >> 3) & 32'd1) << 7) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] m_mret_ms(input logic [31:0] s);
    return (s & ~32'h0000_1888) | (((s >> 7) & 32'd1) << 3) | 32'h0000_1880;
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] tv, input logic [31:0] c, input bit vec);
    logic [31:0] base;
    base = tv & 32'hFFFF_FFFC;
    if (vec && (tv & 32'd3) == 32'd1 && c[31]) return base + (c << 2);
    return base;
  endfunction

  // Monitor: compares accepted writes and redirects against the expected queues
  logic        stall_p = 1'b0;
  logic [11:0] st_addr;
  logic [31:0] st_data;

  always @(negedge clk) begin
    if (rst) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        chk("hold_we", {31'd0, we0}, 32'd1);
        chk("hold_addr", {20'd0, wa0}, {20'd0, st_addr});
        chk("hold_data", wd0, st_data);
      end
      if (we0 && csr_wready) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%h data=%h", wa0, wd0);
        end else begin
          logic [43:0] e;
          e = exp_wr.pop_front();
          checks--;
          chk("wr_addr", {20'd0, wa0}, {20'd0, e[43:32]});
          chk("wr_data", wd0, e[31:0]);
        end
      end
      stall_p = we0 && !csr_wready;
      st_addr = wa0;
      st_data = wd0;
      if (rv0) begin
        if (exp_rd_vec.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_redirect_vec pc=%h", rp0);
        end else chk("redirect_vec", rp0, exp_rd_vec.pop_front());
      end else chk("rpc_zero_vec", rp0, 32'd0);
      if (rv1) begin
        if (exp_rd_dir.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_redirect_dir pc=%h", rp1);
        end else chk("redirect_dir", rp1, exp_rd_dir.pop_front());
      end
    end
  end

  task automatic check_all_zero(input string name);
    chk({name, "_we"}, {31'd0, we0}, 32'd0);
    chk({name, "_waddr"}, {20'd0, wa0}, 32'd0);
    chk({name, "_wdata"}, wd0, 32'd0);
    chk({name, "_flush"}, {31'd0, fl0}, 32'd0);
    chk({name, "_rv"}, {31'd0, rv0}, 32'd0);
    chk({name, "_rpc"}, rp0, 32'd0);
    chk({name, "_busy"}, {31'd0, bz0}, 32'd0);
    chk({name, "_busy_dir"}, {31'd0, bz1}, 32'd0);
  endtask

  task automatic issue(input bit do_trap, input bit do_mret, input logic [31:0] pc,
                       input logic [31:0] cause, input logic [31:0] tval,
                       input logic [31:0] tv, input logic [31:0] epc, input logic [31:0] ms);
    @(posedge clk); #1;
    trap_valid = do_trap; mret_valid = do_mret;
    trap_pc = pc; trap_cause = cause; trap_tval = tval;
    mtvec = tv; mepc = epc; mstatus = ms; csr_wready = 1'b1;
    if (do_trap) begin
      exp_wr.push_back({12'h341, pc & 32'hFFFF_FFFC});
      exp_wr.push_back({12'h342, cause});
      exp_wr.push_back({12'h343, tval});
      exp_wr.push_back({12'h300, m_trap_ms(ms)});
      exp_rd_vec.push_back(m_target(tv, cause, 1'b1));
      exp_rd_dir.push_back(m_target(tv, cause, 1'b0));
    end else if (do_mret) begin
      exp_wr.push_back({12'h300, m_mret_ms(ms)});
      exp_rd_vec.push_back(epc & 32'hFFFF_FFFC);
      exp_rd_dir.push_back(epc & 32'hFFFF_FFFC);
    end
  endtask

  // mode 0: always ready; 1: ready low on sequence cycles 2..4; 2: random ready
  task automatic run(input string name, input bit do_trap, input bit do_mret,
                     input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tval,
                     input logic [31:0] tv, input logic [31:0] epc, input logic [31:0] ms,
                     input int mode, input int exp_cyc);
    int cyc, rk;
    cyc = 0; rk = 0;
    issue(do_trap, do_mret, pc, cause, tval, tv, epc, ms);
    @(negedge clk);
    chk({name, "_flush_accept"}, {31'd0, fl0}, 32'd1);
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      trap_valid = 1'b0; mret_valid = 1'b0;
      case (mode)
        1:       csr_wready = !(i >= 2 && i <= 4);
        2:       csr_wready = ($urandom_range(0, 3) != 0);
        default: csr_wready = 1'b1;
      endcase
      @(negedge clk);
      if (!bz0) break;
      cyc++;
      chk({name, "_flush_busy"}, {31'd0, fl0}, 32'd1);
      if (rv0) rk = i;
      if (i == 60) begin
        checks++; errors++;
        $display("FAIL %s_timeout busy still high after %0d cycles", name, i);
      end
    end
    chk({name, "_idle_flush"}, {31'd0, fl0}, 32'd0);
    chk({name, "_idle_we"}, {31'd0, we0}, 32'd0);
    if (exp_cyc > 0) begin
      chk({name, "_latency"}, cyc, exp_cyc);
      chk({name, "_redirect_cycle"}, rk, exp_cyc);
    end
  endtask

  initial begin
    rst = 1'b1; trap_valid = 1'b0; mret_valid = 1'b0; csr_wready = 1'b1;
    trap_pc = '0; trap_cause = '0; trap_tval = '0; mtvec = '0; mepc = '0; mstatus = '0;
    @(posedge clk); @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    run("illegal", 1, 0, 32'h0000_0104, 32'd2, 32'h0000_0073, 32'h0000_0200, 32'd0, 32'h0000_0008, 0, 5);
    run("vectored", 1, 0, 32'h0000_0400, 32'h8000_0007, 32'd0, 32'h0000_1001, 32'd0, 32'h0000_0008, 0, 5);
    run("mret", 0, 1, 32'd0, 32'd0, 32'd0, 32'd0, 32'h0000_0104, 32'h0000_1880, 0, 2);
    run("backpressure", 1, 0, 32'h0000_2223, 32'h0000_000B, 32'hDEAD_BEEF, 32'h0000_0300, 32'd0, 32'h0000_0080, 1, 8);
    run("trap_and_mret", 1, 1, 32'h0000_0810, 32'h8000_0003, 32'h0000_0011, 32'h0000_0101, 32'h0000_5550, 32'h0000_1888, 0, 5);

    // Reset while the controller is writing mtval
    issue(1, 0, 32'h0000_0900, 32'd5, 32'h0000_0044, 32'h0000_0200, 32'd0, 32'd0);
    @(posedge clk); #1 trap_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_wr.delete(); exp_rd_vec.delete(); exp_rd_dir.delete();
    @(negedge clk);
    chk("rst_mid_addr", {20'd0, wa0}, 32'h0000_0343);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid");
    run("after_reset", 1, 0, 32'h0000_0A00, 32'd1, 32'h0000_0A00, 32'h0000_0200, 32'd0, 32'h0000_0008, 0, 5);

    for (int n = 0; n < 30; n++) begin
      logic [31:0] tv, cs;
      bit dt, dm;
      dt = ($urandom_range(0, 2) != 0);
      dm = dt ? ($urandom_range(0, 1) == 1) : 1'b1;
      tv = $urandom;
      if ($urandom_range(0, 1) == 1) tv[1:0] = 2'b01;
      cs = $urandom;
      if ($urandom_range(0, 1) == 1) cs[30:4] = '0;
      run("random", dt, dm, $urandom, cs, $urandom, tv, $urandom, $urandom, 2, 0);
    end

    @(negedge clk);
    chk("wr_queue_empty", exp_wr.size(), 32'd0);
    chk("rd_vec_queue_empty", exp_rd_vec.size(), 32'd0);
    chk("rd_dir_queue_empty", exp_rd_dir.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
